// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch stage. Issues word-aligned requests to the
//            instruction memory, buffers returned words in a 2-entry
//            {pc, instr} FIFO and feeds the IF/ID register. Execute-stage
//            redirects flush the FIFO and discard in-flight responses.
// Ports    : clk, rst_n (async, active-low)
//            hazard, stall_mem       - hold IF/ID and FIFO head
//            redirect, redirect_pc   - flush and refetch from target
//            imem_req/addr/gnt       - request channel
//            imem_rvalid/rdata       - in-order response channel
//            instruction, next_pc,
//            inst_valid              - IF/ID register to decode
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hazard,
  input  logic        stall_mem,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] next_pc,
  output logic        inst_valid
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] fpc;
  logic [1:0]  outstanding;
  logic [1:0]  drop_cnt;
  // Address queue: PCs of granted requests awaiting a response, oldest first.
  logic [31:0] aq_head;
  logic [31:0] aq_tail;
  logic [31:0] fifo_pc    [2];
  logic [31:0] fifo_instr [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  buf_count;

  logic        grant;
  logic        dropping;
  logic        accept;
  logic        advance;
  logic        bypass;
  logic        fifo_push;
  logic        fifo_pop;
  logic [1:0]  outstanding_nxt;
  logic [1:0]  buf_count_nxt;
  logic [1:0]  drop_cnt_nxt;
  logic        credit_nxt;
  logic        unused_pc_lsb;

  assign grant     = imem_req & imem_gnt;
  assign dropping  = imem_rvalid & (drop_cnt != 2'd0);
  // A response arriving in the redirect cycle belongs to the old path.
  assign accept    = imem_rvalid & (drop_cnt == 2'd0) & ~redirect;
  assign advance   = ~stall_mem & ~hazard & ~redirect;
  // With an empty FIFO the response flows straight into IF/ID (push+pop
  // in the same cycle), which gives one instruction per cycle when streaming.
  assign bypass    = advance & (buf_count == 2'd0) & accept;
  assign fifo_push = accept & ~bypass;
  assign fifo_pop  = advance & (buf_count != 2'd0);

  assign outstanding_nxt = outstanding + {1'b0, grant} - {1'b0, imem_rvalid};
  assign buf_count_nxt   = redirect ? 2'd0
                                    : buf_count + {1'b0, fifo_push} - {1'b0, fifo_pop};
  // A grant taken in the redirect cycle still produces a response, so it is
  // counted among the responses to discard.
  assign drop_cnt_nxt    = redirect ? outstanding_nxt
                                    : (dropping ? drop_cnt - 2'd1 : drop_cnt);
  assign credit_nxt      = ({1'b0, outstanding_nxt} + {1'b0, buf_count_nxt}) < 3'd2;

  assign imem_addr     = fpc;
  assign unused_pc_lsb = ^redirect_pc[1:0];

  // Request FSM. In REQ without a grant the credit sum can only shrink, so
  // holding the request until grant never breaks the in-flight limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      imem_req <= 1'b0;
    end else if (redirect) begin
      state    <= S_WAIT;
      imem_req <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_REQ;
          imem_req <= 1'b1;
        end
        S_REQ: begin
          if (imem_gnt && !credit_nxt) begin
            state    <= S_WAIT;
            imem_req <= 1'b0;
          end
        end
        S_WAIT: begin
          if (credit_nxt && (drop_cnt_nxt == 2'd0)) begin
            state    <= S_REQ;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc           <= 32'h0;
      outstanding   <= 2'd0;
      drop_cnt      <= 2'd0;
      buf_count     <= 2'd0;
      aq_head       <= 32'h0;
      aq_tail       <= 32'h0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      fifo_pc[0]    <= 32'h0;
      fifo_pc[1]    <= 32'h0;
      fifo_instr[0] <= 32'h0;
      fifo_instr[1] <= 32'h0;
      instruction   <= NOP_INSTR;
      next_pc       <= 32'h0;
      inst_valid    <= 1'b0;
    end else begin
      outstanding <= outstanding_nxt;
      drop_cnt    <= drop_cnt_nxt;
      buf_count   <= buf_count_nxt;

      if (redirect) begin
        fpc <= {redirect_pc[31:2], 2'b00};
      end else if (grant) begin
        fpc <= fpc + 32'd4;
      end

      // Every response, kept or dropped, retires the oldest address.
      if (grant && imem_rvalid) begin
        if (outstanding == 2'd2) begin
          aq_head <= aq_tail;
          aq_tail <= fpc;
        end else begin
          aq_head <= fpc;
        end
      end else if (imem_rvalid) begin
        aq_head <= aq_tail;
      end else if (grant) begin
        if (outstanding == 2'd0) begin
          aq_head <= fpc;
        end else begin
          aq_tail <= fpc;
        end
      end

      if (redirect) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (fifo_push) begin
          fifo_pc[wr_ptr]    <= aq_head;
          fifo_instr[wr_ptr] <= imem_rdata;
          wr_ptr             <= ~wr_ptr;
        end
        if (fifo_pop) begin
          rd_ptr <= ~rd_ptr;
        end
      end

      if (redirect) begin
        instruction <= NOP_INSTR;
        inst_valid  <= 1'b0;
      end else if (advance) begin
        if (buf_count != 2'd0) begin
          instruction <= fifo_instr[rd_ptr];
          next_pc     <= fifo_pc[rd_ptr] + 32'd4;
          inst_valid  <= 1'b1;
        end else if (accept) begin
          instruction <= imem_rdata;
          next_pc     <= aq_head + 32'd4;
          inst_valid  <= 1'b1;
        end else begin
          instruction <= NOP_INSTR;
          inst_valid  <= 1'b0;
        end
      end
    end
  end

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_push && !fifo_pop && (buf_count == 2'd2)));

  a_req_within_credit: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_req && (({1'b0, outstanding} + {1'b0, buf_count}) >= 3'd2)));

endmodule
`default_nettype wire
